// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the bus grant arbiter.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  // Decoder enable levels that keep every grant line inactive.
  localparam logic G1_OFF  = 1'b0;
  localparam logic G2A_OFF = 1'b1;
  localparam logic G2B_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Lowest active-low request at or after ptr, wrapping past the top index.
  // The caller only uses the result when at least one request is low.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_n,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && !req_n[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder_3b.sv
// decoder_3b: 3-to-8 decoder with one active-high and two active-low enables,
// active-low one-hot outputs (all high when not enabled).
module decoder_3b (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       g1,
  input  logic       g2a,
  input  logic       g2b,
  output logic [7:0] y_n
);

  // Pull the addressed line low only when all three enables are active.
  always_comb begin
    y_n = 8'hFF;
    if (g1 && !g2a && !g2b) begin
      y_n[{a, b, c}] = 1'b0;
    end
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin grant of one of eight active-low requesters,
// issued through decoder_3b enables.
// Optional macro ARB_TIMEOUT_EN: limit each grant to MAX_HOLD ACTIVE cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant; pick next requester from ptr when any is low
// ST_SETUP   | sel registered, enables off; confirm request still held
// ST_ACTIVE  | enables on, gnt_n[sel] low while the request is held
// ST_RELEASE | enables off, sel held, ptr moves past the served requester
module bus_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_n,
  output logic [SEL_W-1:0]   sel,
  output logic               g1,
  output logic               g2a,
  output logic               g2b,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic               busy,
  output logic               timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("bus_grant_arbiter: MAX_HOLD must be within 1..255");
  end

  arb_state_t       state;
  arb_state_t       state_nx;
  logic [SEL_W-1:0] ptr;
  logic             any_req;
  logic             hold_done;
  logic             en_nx;

  assign any_req = (req_n != '1);
  assign busy    = (state != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Count ACTIVE cycles of the current grant; held at zero outside ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state != ST_ACTIVE) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Pulse timeout during RELEASE only when the limit, not the requester, ended the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state == ST_ACTIVE) && !req_n[sel] && hold_done;
    end
  end
`else
  assign hold_done = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and next enable level.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (any_req) state_nx = ST_SETUP;
      ST_SETUP:   state_nx = req_n[sel] ? ST_IDLE : ST_ACTIVE;
      ST_ACTIVE:  if (req_n[sel] || hold_done) state_nx = ST_RELEASE;
      ST_RELEASE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    en_nx = (state_nx == ST_ACTIVE);
  end

  // State register, selection, round-robin pointer and registered enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      ptr   <= '0;
      g1    <= G1_OFF;
      g2a   <= G2A_OFF;
      g2b   <= G2B_OFF;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && any_req) begin
        sel <= rr_pick(req_n, ptr);
      end
      if (state == ST_RELEASE) begin
        ptr <= sel + 1'b1;
      end
      g1  <= en_nx ? 1'b1 : G1_OFF;
      g2a <= en_nx ? 1'b0 : G2A_OFF;
      g2b <= en_nx ? 1'b0 : G2B_OFF;
    end
  end

  decoder_3b u_decoder (
    .a   (sel[2]),
    .b   (sel[1]),
    .c   (sel[0]),
    .g1  (g1),
    .g2a (g2a),
    .g2b (g2b),
    .y_n (gnt_n)
  );

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb_bus_grant_arbiter: directed and randomized checks of bus_grant_arbiter
// against a behavioural reference model.
module tb_bus_grant_arbiter;

  localparam int TB_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int M_HOLD = TB_HOLD;
`else
  localparam int M_HOLD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_n;
  logic [2:0] sel;
  logic       g1, g2a, g2b;
  logic [7:0] gnt_n;
  logic       busy, timeout;
  logic [15:0] dut_vec;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: phase 0 idle, 1 setup, 2 granted, 3 release.
  int   m_phase = 0;
  int   m_ptr   = 0;
  int   m_sel   = 0;
  int   m_hold  = 0;
  logic m_to    = 1'b0;

  always #5 clk = ~clk;

  bus_grant_arbiter #(.MAX_HOLD(TB_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_n   (req_n),
    .sel     (sel),
    .g1      (g1),
    .g2a     (g2a),
    .g2b     (g2b),
    .gnt_n   (gnt_n),
    .busy    (busy),
    .timeout (timeout)
  );

  assign dut_vec = {sel, g1, g2a, g2b, gnt_n, busy, timeout};

  function automatic int first_from(input int p, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (!r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [7:0] r, input logic rs);
    if (!rs) begin
      m_phase = 0; m_ptr = 0; m_sel = 0; m_hold = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    case (m_phase)
      0: if (r != 8'hFF) begin m_sel = first_from(m_ptr, r); m_phase = 1; end
      1: begin
        m_hold  = 0;
        m_phase = r[m_sel] ? 0 : 2;
      end
      2: begin
        m_hold++;
        if (r[m_sel]) m_phase = 3;
        else if (M_HOLD > 0 && m_hold == M_HOLD) begin m_phase = 3; m_to = 1'b1; end
      end
      default: begin
        m_ptr   = (m_sel + 1) % 8;
        m_phase = 0;
      end
    endcase
  endfunction

  function automatic logic [15:0] exp_vec();
    logic       en;
    logic [7:0] g;
    en = (m_phase == 2);
    g  = en ? ~(8'b1 << m_sel) : 8'hFF;
    return {m_sel[2:0], en, !en, !en, g, (m_phase != 0), m_to};
  endfunction

  task automatic tick(input logic [7:0] r, input logic rs);
    req_n = r;
    rst_n = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic test_reset();
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);
    n_vec++;
    if (dut_vec !== {3'd0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_state: got %h want %h", dut_vec, {3'd0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0});
    end
    tick(8'hFF, 1'b1);
    n_vec++;
    if (busy !== 1'b0 || gnt_n !== 8'hFF) begin
      n_miss++;
      $display("FAIL reset_idle: busy=%b gnt_n=%h want 0/ff", busy, gnt_n);
    end
  endtask

  task automatic test_single();
    tick(8'hFB, 1'b1);
    n_vec++;
    if (sel !== 3'd2 || busy !== 1'b1 || gnt_n !== 8'hFF) begin
      n_miss++;
      $display("FAIL single_setup: sel=%0d busy=%b gnt_n=%h want 2/1/ff", sel, busy, gnt_n);
    end
    tick(8'hFB, 1'b1);
    n_vec++;
    if (gnt_n !== 8'hFB || g1 !== 1'b1 || g2a !== 1'b0 || g2b !== 1'b0) begin
      n_miss++;
      $display("FAIL single_grant: gnt_n=%h g=%b%b%b want fb/100", gnt_n, g1, g2a, g2b);
    end
    tick(8'hFB, 1'b1);
    tick(8'hFF, 1'b1);
    n_vec++;
    if (gnt_n !== 8'hFF || busy !== 1'b1 || sel !== 3'd2) begin
      n_miss++;
      $display("FAIL single_release: gnt_n=%h busy=%b sel=%0d want ff/1/2", gnt_n, busy, sel);
    end
    tick(8'hFF, 1'b1);
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL single_idle: busy=%b want 0", busy);
    end
    tick(8'h00, 1'b1);
    n_vec++;
    if (sel !== 3'd3) begin
      n_miss++;
      $display("FAIL single_ptr: sel=%0d want 3", sel);
    end
    tick(8'hFF, 1'b1);
  endtask

  task automatic test_setup_abort();
    tick(8'hDF, 1'b1);
    n_vec++;
    if (sel !== 3'd5 || busy !== 1'b1 || gnt_n !== 8'hFF) begin
      n_miss++;
      $display("FAIL abort_setup: sel=%0d busy=%b gnt_n=%h want 5/1/ff", sel, busy, gnt_n);
    end
    tick(8'hFF, 1'b1);
    n_vec++;
    if (busy !== 1'b0 || gnt_n !== 8'hFF || g1 !== 1'b0) begin
      n_miss++;
      $display("FAIL abort_idle: busy=%b gnt_n=%h g1=%b want 0/ff/0", busy, gnt_n, g1);
    end
    tick(8'h00, 1'b1);
    n_vec++;
    if (sel !== 3'd3) begin
      n_miss++;
      $display("FAIL abort_ptr: sel=%0d want 3", sel);
    end
    tick(8'hFF, 1'b1);
  endtask

  task automatic test_round_robin();
    logic [7:0] r;
    logic [7:0] prev;
    int act    = 0;
    int grants = 0;
    int idx;
    tick(8'hFF, 1'b0);
    tick(8'hFF, 1'b1);
    prev = 8'hFF;
    for (int c = 0; c < 300 && grants < 9; c++) begin
      r = 8'h00;
      if (act >= 3) r[m_sel] = 1'b1;
      tick(r, 1'b1);
      act = (m_phase == 2) ? act + 1 : 0;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_miss++;
        $display("FAIL rr_cycle: got %h want %h", dut_vec, exp_vec());
      end
      if (prev == 8'hFF && gnt_n != 8'hFF) begin
        idx = -1;
        for (int b = 0; b < 8; b++) if (!gnt_n[b]) idx = b;
        n_vec++;
        if (idx != grants % 8) begin
          n_miss++;
          $display("FAIL rr_order: grant %0d went to %0d want %0d", grants, idx, grants % 8);
        end
        grants++;
      end
      prev = gnt_n;
    end
    n_vec++;
    if (grants != 9) begin
      n_miss++;
      $display("FAIL rr_count: saw %0d grants want 9", grants);
    end
    tick(8'hFF, 1'b1);
    tick(8'hFF, 1'b1);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int run = 0, first_len = 0, runs = 0, pulses = 0;
    logic regrant = 1'b0;
    tick(8'hFF, 1'b0);
    tick(8'hFF, 1'b1);
    for (int c = 0; c < 40 && !regrant; c++) begin
      tick(8'hFE, 1'b1);
      if (timeout) pulses++;
      if (!gnt_n[0]) begin
        if (runs == 1) regrant = 1'b1;
        run++;
      end else if (run > 0) begin
        if (runs == 0) first_len = run;
        runs++;
        run = 0;
      end
    end
    n_vec++;
    if (first_len != TB_HOLD) begin
      n_miss++;
      $display("FAIL to_len: grant lasted %0d cycles want %0d", first_len, TB_HOLD);
    end
    n_vec++;
    if (pulses != 1) begin
      n_miss++;
      $display("FAIL to_pulse: %0d pulses want 1", pulses);
    end
    n_vec++;
    if (!regrant) begin
      n_miss++;
      $display("FAIL to_regrant: regrant=%b want 1", regrant);
    end
    tick(8'hFF, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_active();
    tick(8'hFF, 1'b0);
    tick(8'hFF, 1'b1);
    tick(8'hF7, 1'b1);
    tick(8'hF7, 1'b1);
    tick(8'hF7, 1'b1);
    tick(8'hFF, 1'b1);
    tick(8'hFF, 1'b1);
    tick(8'hBF, 1'b1);
    tick(8'hBF, 1'b1);
    n_vec++;
    if (gnt_n !== 8'hBF) begin
      n_miss++;
      $display("FAIL mid_grant: gnt_n=%h want bf", gnt_n);
    end
    tick(8'hBF, 1'b0);
    n_vec++;
    if (gnt_n !== 8'hFF || g1 !== 1'b0 || busy !== 1'b0 || sel !== 3'd0) begin
      n_miss++;
      $display("FAIL mid_reset: gnt_n=%h g1=%b busy=%b sel=%0d want ff/0/0/0", gnt_n, g1, busy, sel);
    end
    tick(8'h00, 1'b1);
    n_vec++;
    if (sel !== 3'd0) begin
      n_miss++;
      $display("FAIL mid_ptr: sel=%0d want 0", sel);
    end
    tick(8'hFF, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] r = 8'hFF;
    logic       rs;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom) | 8'($urandom);
      rs = ($urandom_range(0, 79) != 0);
      tick(r, rs);
      n_vec++;
      if (dut_vec !== exp_vec() || $countones(~gnt_n) > 1) begin
        n_miss++;
        $display("FAIL random_cycle %0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_n = 8'hFF;
    test_reset();
    test_single();
    test_setup_abort();
    test_round_robin();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_active();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
